fetch_queue_controller: RTL
===========================

FETCH_QUEUE_CONTROLLER -- requirements
Module: fetch_queue_controller

Interface
REQ-001 SHALL have parameters: XLEN, default 32, PC/instruction width; LINE_WORDS, default 4, instructions per cache line (power of 2, >=2); FQ_DEPTH, default 8, fetch-queue entries (power of 2, >=LINE_WORDS); BOOT_PC, default 0, fetch PC after reset.
REQ-002 SHALL have ports: clk_i in 1 clock; rst_n_i in 1 reset; flush_i in 1 redirect; flush_pc_i in XLEN redirect target; cache_req_valid_o out 1 line request; cache_req_ready_i in 1 cache accepts request; cache_req_addr_o out XLEN line-aligned address; cache_resp_valid_i in 1 line returned; cache_resp_line_i in LINE_WORDS*XLEN line data, word 0 in LSBs; issue_valid_o out 1 instruction available; issue_ready_i in 1 issue accepts; issue_instr_o out XLEN instruction; issue_pc_o out XLEN its PC; fq_count_o out $clog2(FQ_DEPTH)+1 occupied entries.
REQ-003 SHALL use one clock, clk_i; reset rst_n_i is asynchronous, active-low.

Function
REQ-004 SHALL keep fetch PC fpc; word offset off = fpc[$clog2(LINE_WORDS)+1:2]; need = LINE_WORDS-off.
REQ-005 SHALL implement FSM states RESET, IDLE, REQ, WAIT.
REQ-006 RESET SHALL go to IDLE unconditionally after one cycle; all outputs 0 in RESET.
REQ-007 IDLE SHALL go to REQ when free entries (FQ_DEPTH-count) >= need, else stay.
REQ-008 REQ SHALL drive cache_req_valid_o=1, cache_req_addr_o=fpc with low $clog2(LINE_WORDS)+2 bits cleared; go to WAIT on cache_req_ready_i, else hold request and address stable.
REQ-009 WAIT SHALL, on cache_resp_valid_i, write words off..LINE_WORDS-1 into queue in one cycle in ascending PC order, set fpc to next line base, go to IDLE; at most one request outstanding.
REQ-010 Each queue entry SHALL store instruction and PC; issue_instr_o/issue_pc_o SHALL reflect head entry; issue_valid_o = (count!=0).
REQ-011 Pop SHALL occur when issue_valid_o && issue_ready_i; simultaneous pop and line write in same cycle SHALL both take effect; count updates by (written - popped).
REQ-012 Space check in IDLE SHALL use registered count (pops in the same cycle not credited); overflow impossible by construction.
REQ-013 Read/write pointers SHALL wrap modulo FQ_DEPTH; full (count=FQ_DEPTH) and empty (count=0) SHALL be exact.
REQ-014 flush_i SHALL, next cycle: count=0, pointers reset, fpc=flush_pc_i, state IDLE; issue_valid_o=0 in the cycle after flush; flush has priority over push/pop same cycle.
REQ-015 Flush in REQ after handshake or in WAIT SHALL set a drop flag; next cache_resp_valid_i SHALL be discarded and clear the flag; no new request issued while flag set.
REQ-016 Flush in REQ before handshake SHALL withdraw the request (cache_req_valid_o=0 next cycle).
REQ-017 fpc SHALL wrap modulo 2^XLEN at top of address space.
REQ-018 flush_pc_i low 2 bits SHALL be ignored (treated as 0).

Reset
REQ-019 On rst_n_i low: state RESET, fpc=BOOT_PC, count=0, pointers 0, drop flag 0, cache_req_valid_o=0, issue_valid_o=0, issue_instr_o=0, issue_pc_o=0, fq_count_o=0.
REQ-020 Reset mid-transaction SHALL abandon any outstanding request; no response discard after reset (cache reset concurrently).

Configuration
REQ-021 Macro FETCH_BYPASS_EN: when defined and queue empty in WAIT, response word off SHALL be presented on issue outputs combinationally same cycle (issue_valid_o=1); if issue_ready_i, that word is not stored, remaining words queued.
REQ-022 Without FETCH_BYPASS_EN, response words SHALL be visible on issue outputs no earlier than the cycle after cache_resp_valid_i.

Verification
REQ-023 Reset, BOOT_PC=0x100, cache ready, response one cycle later, issue_ready=1 -> cache_req_addr_o=0x100, PCs 0x100,0x104,0x108,0x10C issued in order, next request 0x110.
REQ-024 flush_pc_i=0x208 -> request addr 0x200, only PCs 0x208,0x20C queued, fq_count_o=2.
REQ-025 issue_ready=0 throughout -> queue fills to 8 after two lines, no third request; one pop -> still no request until count<=4.
REQ-026 Flush in WAIT to 0x400, stale response arrives -> response dropped, fq_count_o=0, next request addr 0x400 only after stale response.
REQ-027 FETCH_BYPASS_EN defined, empty queue, issue_ready=1 -> PC 0x100 issued in response cycle, fq_count_o=3 next cycle; undefined -> issue_valid_o first high the cycle after response, fq_count_o=4.

Source files
------------

// File: rtl/fetch_queue_controller.sv
// Fetch queue controller: requests I-cache lines, queues the returned words and issues them in
// PC order. Optional macro FETCH_BYPASS_EN forwards the first response word straight to issue.
module fetch_queue_controller #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     LINE_WORDS = 4,
    parameter int unsigned     FQ_DEPTH   = 8,
    parameter logic [XLEN-1:0] BOOT_PC    = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            flush_pc_i,
    output logic                       cache_req_valid_o,
    input  logic                       cache_req_ready_i,
    output logic [XLEN-1:0]            cache_req_addr_o,
    input  logic                       cache_resp_valid_i,
    input  logic [LINE_WORDS*XLEN-1:0] cache_resp_line_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [XLEN-1:0]            issue_instr_o,
    output logic [XLEN-1:0]            issue_pc_o,
    output logic [$clog2(FQ_DEPTH):0]  fq_count_o
);

    localparam int unsigned OffW    = $clog2(LINE_WORDS);
    localparam int unsigned PtrW    = $clog2(FQ_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned FirstW  = OffW + 1;
    localparam int unsigned LineLsb = OffW + 2;

    typedef enum logic [1:0] {StReset, StIdle, StReq, StWait} state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_req_valid;
    logic            r_drop;
    logic [CntW-1:0] r_count;
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [XLEN-1:0] r_instr_mem [FQ_DEPTH];
    logic [XLEN-1:0] r_pc_mem    [FQ_DEPTH];

    logic [OffW-1:0]       w_off;
    logic [XLEN-1:0]       w_line_base;
    logic [CntW-1:0]       w_need;
    logic [CntW-1:0]       w_free;
    logic                  w_empty;
    logic                  w_resp_take;
    logic                  w_bypass;
    logic                  w_byp_take;
    logic                  w_pop;
    logic [FirstW-1:0]     w_first;
    logic [CntW-1:0]       w_written;
    logic [XLEN-1:0]       w_byp_instr;
    logic                  w_drop_set;
    logic [LINE_WORDS-1:0] w_we;
    logic [PtrW-1:0]       w_slot [LINE_WORDS];

    assign w_off       = r_fpc[LineLsb-1:2];
    assign w_line_base = {r_fpc[XLEN-1:LineLsb], {LineLsb{1'b0}}};
    assign w_need      = CntW'(LINE_WORDS) - CntW'(w_off);
    assign w_free      = CntW'(FQ_DEPTH) - r_count;
    assign w_empty     = (r_count == '0);
    assign w_resp_take = (r_state == StWait) && cache_resp_valid_i;
    assign w_byp_instr = cache_resp_line_i[w_off*XLEN +: XLEN];

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_resp_take && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word that is accepted never enters the queue.
    assign w_byp_take = w_bypass && issue_ready_i;
    assign w_pop      = !w_empty && issue_ready_i;
    assign w_first    = FirstW'(w_off) + FirstW'(w_byp_take);
    assign w_written  = w_resp_take ? (w_need - CntW'(w_byp_take)) : '0;

    // An accepted request whose response is still to come must have that response discarded.
    assign w_drop_set = flush_i && (((r_state == StReq) && cache_req_ready_i) ||
                                    ((r_state == StWait) && !cache_resp_valid_i));

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            w_we[i]   = w_resp_take && !flush_i && (FirstW'(i) >= w_first);
            w_slot[i] = r_wr_ptr + PtrW'(i) - PtrW'(w_first);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (w_we[i]) begin
                r_instr_mem[w_slot[i]] <= cache_resp_line_i[i*XLEN +: XLEN];
                r_pc_mem[w_slot[i]]    <= w_line_base + XLEN'(i * 4);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StReset;
            r_fpc       <= {BOOT_PC[XLEN-1:2], 2'b00};
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_drop      <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_drop <= w_drop_set || (r_drop && !cache_resp_valid_i);
            if (flush_i) begin
                r_state     <= StIdle;
                r_fpc       <= {flush_pc_i[XLEN-1:2], 2'b00};
                r_req_valid <= 1'b0;
                r_req_addr  <= '0;
                r_count     <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
            end else begin
                r_count  <= r_count + w_written - CntW'(w_pop);
                r_wr_ptr <= r_wr_ptr + PtrW'(w_written);
                r_rd_ptr <= r_rd_ptr + PtrW'(w_pop);
                unique case (r_state)
                    StReset: r_state <= StIdle;
                    StIdle: begin
                        if (!r_drop && (w_free >= w_need)) begin
                            r_state     <= StReq;
                            r_req_valid <= 1'b1;
                            r_req_addr  <= w_line_base;
                        end
                    end
                    StReq: begin
                        if (cache_req_ready_i) begin
                            r_state     <= StWait;
                            r_req_valid <= 1'b0;
                            r_req_addr  <= '0;
                        end
                    end
                    StWait: begin
                        if (cache_resp_valid_i) begin
                            r_state <= StIdle;
                            r_fpc   <= w_line_base + XLEN'(LINE_WORDS * 4);
                        end
                    end
                    default: r_state <= StReset;
                endcase
            end
        end
    end

    always_comb begin
        issue_valid_o = !w_empty || w_bypass;
        issue_instr_o = '0;
        issue_pc_o    = '0;
        if (!w_empty) begin
            issue_instr_o = r_instr_mem[r_rd_ptr];
            issue_pc_o    = r_pc_mem[r_rd_ptr];
        end else if (w_bypass) begin
            issue_instr_o = w_byp_instr;
            issue_pc_o    = r_fpc;
        end
    end

    assign cache_req_valid_o = r_req_valid;
    assign cache_req_addr_o  = r_req_addr;
    assign fq_count_o        = r_count;

endmodule
